// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART RX word path.
// The UART_RX_CHECKSUM_EN build uses xor_bytes() to validate trailing checksum bytes.
package uart_rx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2,
    FLUSH   = 2'd3
  } rx_state_t;

  // XOR of the lowest n_bytes bytes of word (up to four).
  function automatic logic [BYTE_W-1:0] xor_bytes(input logic [31:0] word, input int n_bytes);
    logic [BYTE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n_bytes) acc = acc ^ word[i*BYTE_W +: BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Loadable down-counter: restart_i reloads it, enable_i counts it down,
// and expired_o is high once the count has reached zero.
module uart_rx_timeout #(
  parameter int CYCLES = 1_000_000,
  localparam int TW    = $clog2(CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Load CYCLES-1 so that expiry is reached after exactly CYCLES enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = TW'(CYCLES - 1);
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs consecutive UART RX bytes into one OUT_WIDTH-bit word with a one-cycle valid strobe.
// Define UART_RX_CHECKSUM_EN to require a trailing XOR checksum byte after each word.
module uart_rx_word_assembler
  import uart_rx_pkg::*;
#(
  parameter int BYTES          = 2,
  parameter int OUT_WIDTH      = 12,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int IDX_W         = ($clog2(BYTES + 1) > 1) ? $clog2(BYTES + 1) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_ready,
  input  logic [BYTE_W-1:0]    rx_data,
  output logic [OUT_WIDTH-1:0] word_data,
  output logic                 word_valid,
  output logic [IDX_W-1:0]     byte_index,
  output logic [1:0]           state_id,
  output logic                 frame_error
);

  localparam int SHW = BYTE_W * BYTES;

  rx_state_t            state_q, state_d;
  logic [SHW-1:0]       shift_q, shift_d, shift_in;
  logic [IDX_W-1:0]     count_q, count_d;
  logic [OUT_WIDTH-1:0] word_q, word_d;
  logic                 tmo_expired;

  // Shift direction decides where the first byte of a word ends up.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign shift_in = SHW'({shift_q, rx_data});
  end else begin : g_lsb_first
    assign shift_in = SHW'({rx_data, shift_q} >> BYTE_W);
  end

  uart_rx_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .restart_i(rx_ready),
    .enable_i (state_q == COLLECT),
    .expired_o(tmo_expired)
  );

  // count_q is zero outside COLLECT, so a byte arriving in any state is handled alike.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    word_d  = word_q;

    unique case (state_q)
      PUBLISH, FLUSH: begin
        state_d = IDLE;
        count_d = '0;
      end
      COLLECT: begin
        if (!rx_ready && tmo_expired) begin
          state_d = FLUSH;
          count_d = '0;
        end
      end
      default: ;
    endcase

    if (rx_ready) begin
`ifdef UART_RX_CHECKSUM_EN
      if (count_q == IDX_W'(BYTES)) begin
        count_d = '0;
        if (rx_data == xor_bytes(32'(shift_q), BYTES)) begin
          state_d = PUBLISH;
          word_d  = OUT_WIDTH'(shift_q);
        end else begin
          state_d = FLUSH;
        end
      end else begin
        shift_d = shift_in;
        count_d = count_q + IDX_W'(1);
        state_d = COLLECT;
      end
`else
      shift_d = shift_in;
      if (count_q == IDX_W'(BYTES - 1)) begin
        state_d = PUBLISH;
        count_d = '0;
        word_d  = OUT_WIDTH'(shift_in);
      end else begin
        state_d = COLLECT;
        count_d = count_q + IDX_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  assign word_data   = word_q;
  assign word_valid  = (state_q == PUBLISH);
  assign frame_error = (state_q == FLUSH);
  assign byte_index  = count_q;
  assign state_id    = state_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench: per-cycle vector table on an MSB-first 12-bit instance,
// plus hand sequences for reset mid-word and an LSB-first 16-bit instance.
module tb_uart_rx_word_assembler;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        rdy_a, rdy_b;
  logic [7:0]  data_a, data_b;
  logic [11:0] word_a;
  logic [15:0] word_b;
  logic        valid_a, valid_b, ferr_a, ferr_b;
  logic [1:0]  idx_a, idx_b, st_a, st_b;

  uart_rx_word_assembler #(
    .BYTES(2), .OUT_WIDTH(12), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .rx_ready(rdy_a), .rx_data(data_a),
    .word_data(word_a), .word_valid(valid_a), .byte_index(idx_a),
    .state_id(st_a), .frame_error(ferr_a)
  );

  uart_rx_word_assembler #(
    .BYTES(2), .OUT_WIDTH(16), .MSB_FIRST(0), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .rx_ready(rdy_b), .rx_data(data_b),
    .word_data(word_b), .word_valid(valid_b), .byte_index(idx_b),
    .state_id(st_b), .frame_error(ferr_b)
  );

  typedef struct {
    logic        rdy;
    logic [7:0]  data;
    logic [15:0] word;
    logic        valid;
    logic [1:0]  st;
    logic [1:0]  idx;
    logic        ferr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic rdy, input logic [7:0] data, input logic [15:0] word,
                     input logic valid, input logic [1:0] st, input logic [1:0] idx,
                     input logic ferr);
    vec_t v;
    v.rdy = rdy; v.data = data; v.word = word; v.valid = valid;
    v.st = st; v.idx = idx; v.ferr = ferr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [15:0] word, input logic valid,
                         input logic [1:0] st, input logic [1:0] idx, input logic ferr);
    check({tag, " word_data"},   32'(word_a),  32'(word));
    check({tag, " word_valid"},  32'(valid_a), 32'(valid));
    check({tag, " state_id"},    32'(st_a),    32'(st));
    check({tag, " byte_index"},  32'(idx_a),   32'(idx));
    check({tag, " frame_error"}, 32'(ferr_a),  32'(ferr));
  endtask

  task automatic send_a(input logic [7:0] b);
    @(negedge clock);
    rdy_a  = 1'b1;
    data_a = b;
  endtask

  initial begin
    logic [7:0] word_bytes[$];
    logic [7:0] b_bytes[$];
    rdy_a = 1'b0; data_a = '0; rdy_b = 1'b0; data_b = '0;

`ifdef UART_RX_CHECKSUM_EN
    add(1, 8'h0A, 16'h000, 0, 0, 0, 0);
    add(1, 8'hBC, 16'h000, 0, 1, 1, 0);
    add(1, 8'hB6, 16'h000, 0, 1, 2, 0);
    add(0, 8'h00, 16'hABC, 1, 2, 0, 0);
    add(1, 8'h0A, 16'hABC, 0, 0, 0, 0);
    add(1, 8'hBC, 16'hABC, 0, 1, 1, 0);
    add(1, 8'h00, 16'hABC, 0, 1, 2, 0);
    add(0, 8'h00, 16'hABC, 0, 3, 0, 1);
    add(0, 8'h00, 16'hABC, 0, 0, 0, 0);
    word_bytes = '{8'h01, 8'h23, 8'h22};
    b_bytes    = '{8'h34, 8'h12, 8'h26};
`else
    // Two bytes three cycles apart
    add(1, 8'h0A, 16'h000, 0, 0, 0, 0);
    add(0, 8'h00, 16'h000, 0, 1, 1, 0);
    add(0, 8'h00, 16'h000, 0, 1, 1, 0);
    add(1, 8'hBC, 16'h000, 0, 1, 1, 0);
    add(0, 8'h00, 16'hABC, 1, 2, 0, 0);
    add(0, 8'h00, 16'hABC, 0, 0, 0, 0);
    // Back-to-back strobes, byte captured during PUBLISH
    add(1, 8'h01, 16'hABC, 0, 0, 0, 0);
    add(1, 8'h23, 16'hABC, 0, 1, 1, 0);
    add(1, 8'h04, 16'h123, 1, 2, 0, 0);
    add(1, 8'h56, 16'h123, 0, 1, 1, 0);
    add(0, 8'h00, 16'h456, 1, 2, 0, 0);
    add(0, 8'h00, 16'h456, 0, 0, 0, 0);
    // Timeout after 16 idle cycles, then a clean word
    add(1, 8'h0A, 16'h456, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 8'h00, 16'h456, 0, 1, 1, 0);
    add(0, 8'h00, 16'h456, 0, 3, 0, 1);
    add(1, 8'h01, 16'h456, 0, 0, 0, 0);
    add(1, 8'h23, 16'h456, 0, 1, 1, 0);
    add(0, 8'h00, 16'h123, 1, 2, 0, 0);
    add(0, 8'h00, 16'h123, 0, 0, 0, 0);
    // Second byte in the last cycle before expiry is still accepted
    add(1, 8'h07, 16'h123, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 8'h00, 16'h123, 0, 1, 1, 0);
    add(1, 8'h89, 16'h123, 0, 1, 1, 0);
    add(0, 8'h00, 16'h789, 1, 2, 0, 0);
    add(0, 8'h00, 16'h789, 0, 0, 0, 0);
    // Byte arriving during FLUSH starts a new word
    add(1, 8'h0A, 16'h789, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 8'h00, 16'h789, 0, 1, 1, 0);
    add(1, 8'h04, 16'h789, 0, 3, 0, 1);
    add(1, 8'h56, 16'h789, 0, 1, 1, 0);
    add(0, 8'h00, 16'h456, 1, 2, 0, 0);
    add(0, 8'h00, 16'h456, 0, 0, 0, 0);
    word_bytes = '{8'h01, 8'h23};
    b_bytes    = '{8'h34, 8'h12};
`endif

    // Reset state
    repeat (2) @(negedge clock);
    check_a("reset", 16'h000, 0, 0, 0, 0);
    check("reset b word_data", 32'(word_b), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      $display("vec %0d rx_ready=%0d rx_data=%02h word=%03h valid=%0d state=%0d idx=%0d ferr=%0d",
               i, vecs[i].rdy, vecs[i].data, word_a, valid_a, st_a, idx_a, ferr_a);
      check_a($sformatf("vec%0d", i), vecs[i].word, vecs[i].valid, vecs[i].st,
              vecs[i].idx, vecs[i].ferr);
      rdy_a  = vecs[i].rdy;
      data_a = vecs[i].data;
    end
    @(negedge clock);
    rdy_a = 1'b0;

    // Reset asserted mid-word discards the partial word
    send_a(8'h0A);
    @(negedge clock);
    rdy_a = 1'b0;
    check("midword state_id", 32'(st_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check_a("midreset", 16'h000, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    foreach (word_bytes[k]) send_a(word_bytes[k]);
    @(negedge clock);
    rdy_a = 1'b0;
    $display("post-reset word=%03h valid=%0d", word_a, valid_a);
    check_a("postreset", 16'h123, 1, 2, 0, 0);
    @(negedge clock);
    check("postreset strobe end", 32'(valid_a), 32'd0);

    // LSB-first packing on the 16-bit instance
    foreach (b_bytes[k]) begin
      @(negedge clock);
      rdy_b  = 1'b1;
      data_b = b_bytes[k];
    end
    @(negedge clock);
    rdy_b = 1'b0;
    $display("lsb-first word=%04h valid=%0d", word_b, valid_b);
    check("lsb word_data", 32'(word_b), 32'h1234);
    check("lsb word_valid", 32'(valid_b), 32'd1);
    @(negedge clock);
    check("lsb strobe end", 32'(valid_b), 32'd0);
    check("lsb state_id", 32'(st_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
